// File: rtl/arm_mc_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath (slave): instruction fields and flags in, enables and selects out.
interface arm_mc_controller_if;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] flags_q;
    logic [3:0] state;

    modport master (
        input  cond, op, funct, rd, alu_flags, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_src, flags_q, state
    );

    modport slave (
        output cond, op, funct, rd, alu_flags, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_src, flags_q, state
    );
endinterface

// File: rtl/arm_mc_controller.sv
// Multicycle ARM-subset control unit: Moore main FSM, ALU decoder, NZCV flag
// register and condition-gated write enables for the shared-memory datapath.
module arm_mc_controller #(
    parameter int MEM_WAIT = 1
) (
    input logic                  clk,
    input logic                  rst,
    arm_mc_controller_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flags;
    logic       rdy;

    logic       ir_raw;
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       alu_op;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       pcs;

    assign rdy = bus.mem_ready || (MEM_WAIT == 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (rdy) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = bus.funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = bus.funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (rdy) state_d = MEMWB;
            MEMWR:  if (rdy) state_d = FETCH;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            MEMWB:  state_d = FETCH;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ir_raw         = 1'b0;
        next_pc        = 1'b0;
        branch         = 1'b0;
        reg_w          = 1'b0;
        mem_w          = 1'b0;
        alu_op         = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        case (state_q)
            FETCH: begin
                ir_raw         = 1'b1;
                next_pc        = 1'b1;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            DECODE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            MEMADR: bus.alu_src_b = 2'b01;
            MEMRD:  bus.adr_src = 1'b1;
            MEMWB: begin
                bus.result_src = 2'b01;
                reg_w          = 1'b1;
            end
            MEMWR: begin
                bus.adr_src = 1'b1;
                mem_w       = 1'b1;
            end
            EXECR:  alu_op = 1'b1;
            EXECI: begin
                bus.alu_src_b = 2'b01;
                alu_op        = 1'b1;
            end
            ALUWB:  reg_w = 1'b1;
            BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                branch         = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsupported commands fall back to ADD and must never touch the flags.
    always_comb begin
        bus.alu_control = 2'b00;
        flag_w          = 2'b00;
        if (alu_op) begin
            case (bus.funct[4:1])
                4'b0100: begin
                    bus.alu_control = 2'b00;
                    flag_w          = {2{bus.funct[0]}};
                end
                4'b0010: begin
                    bus.alu_control = 2'b01;
                    flag_w          = {2{bus.funct[0]}};
                end
                4'b0000: begin
                    bus.alu_control = 2'b10;
                    flag_w          = {bus.funct[0], 1'b0};
                end
                4'b1100: begin
                    bus.alu_control = 2'b11;
                    flag_w          = {bus.funct[0], 1'b0};
                end
                default: begin
                    bus.alu_control = 2'b00;
                    flag_w          = 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (bus.cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = !flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = !flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = !flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = !flags[0];
            4'b1000: cond_ex = flags[1] && !flags[2];
            4'b1001: cond_ex = !flags[1] || flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags <= '0;
        end else if ((state_q == EXECR || state_q == EXECI) && cond_ex) begin
            if (flag_w[1]) flags[3:2] <= bus.alu_flags[3:2];
            if (flag_w[0]) flags[1:0] <= bus.alu_flags[1:0];
        end
    end

    assign pcs           = branch || (reg_w && bus.rd == 4'd15);
    assign bus.reg_write = reg_w && cond_ex;
    assign bus.mem_write = mem_w && cond_ex;
    assign bus.pc_write  = (next_pc && rdy) || (pcs && cond_ex);
    assign bus.ir_write  = ir_raw && rdy;
    assign bus.imm_src   = bus.op;
    assign bus.reg_src   = {bus.op == 2'b01, bus.op == 2'b10};
    assign bus.flags_q   = flags;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: walks instruction classes through the
// FSM with hand-computed state traces, write counts and flag values.
module tb_arm_mc_controller;
    logic clk = 1'b0;
    logic rst;
    logic rst0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    arm_mc_controller_if bus ();
    arm_mc_controller_if bus0 ();

    assign bus0.cond      = bus.cond;
    assign bus0.op        = bus.op;
    assign bus0.funct     = bus.funct;
    assign bus0.rd        = bus.rd;
    assign bus0.alu_flags = bus.alu_flags;
    assign bus0.mem_ready = bus.mem_ready;

    arm_mc_controller #(.MEM_WAIT(1)) u_dut  (.clk(clk), .rst(rst),  .bus(bus));
    arm_mc_controller #(.MEM_WAIT(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));

    int          cyc_n;
    int          rw_n;
    int          mw_n;
    int          pw_n;
    int          pw_late_n;
    int          ir_n;
    logic [31:0] seq;
    logic [1:0]  src_at_rw;
    logic [1:0]  src_at_pw;
    logic [1:0]  ctl_ex;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r,
                             input logic [3:0] af);
        bus.cond      = c;
        bus.op        = o;
        bus.funct     = f;
        bus.rd        = r;
        bus.alu_flags = af;
    endtask

    // Runs one instruction from FETCH back to FETCH, stalling mem_ready as asked.
    task automatic run(input int fetch_waits, input int mem_waits);
        int  wf   = 0;
        int  wm   = 0;
        bit  left = 1'b0;
        cyc_n = 0; rw_n = 0; mw_n = 0; pw_n = 0; pw_late_n = 0; ir_n = 0;
        seq = '0; src_at_rw = 2'b11; src_at_pw = 2'b11; ctl_ex = 2'b00;
        do begin
            if (bus.state == 4'd0 && wf < fetch_waits) begin
                bus.mem_ready = 1'b0; wf++;
            end else if ((bus.state == 4'd3 || bus.state == 4'd5) && wm < mem_waits) begin
                bus.mem_ready = 1'b0; wm++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            cyc_n++;
            seq   = {seq[27:0], bus.state};
            rw_n += int'(bus.reg_write);
            mw_n += int'(bus.mem_write);
            pw_n += int'(bus.pc_write);
            ir_n += int'(bus.ir_write);
            if (bus.reg_write) src_at_rw = bus.result_src;
            if (bus.pc_write && bus.state != 4'd0) begin
                pw_late_n++;
                src_at_pw = bus.result_src;
            end
            if (bus.state == 4'd6 || bus.state == 4'd7) ctl_ex = bus.alu_control;
            step();
            if (bus.state != 4'd0) left = 1'b1;
        end while (!(left && bus.state == 4'd0) && cyc_n < 24);
        chk("run_timeout", 32'(cyc_n < 24), 32'd1);
    endtask

    initial begin
        rst  = 1'b0;
        rst0 = 1'b0;
        bus.mem_ready = 1'b0;
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);

        // Reset with memory stalled, then with memory ready
        #12;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_flags", 32'(bus.flags_q), 32'h0);
        chk("rst_pcw_stall", 32'(bus.pc_write), 32'd0);
        chk("rst_irw_stall", 32'(bus.ir_write), 32'd0);
        chk("rst_srcb", 32'(bus.alu_src_b), 32'd2);
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_pcw_rdy", 32'(bus.pc_write), 32'd1);
        chk("rst_irw_rdy", 32'(bus.ir_write), 32'd1);
        rst = 1'b1;
        step();
        chk("rel_state", 32'(bus.state), 32'd1);
        step();
        chk("undef_back", 32'(bus.state), 32'd0);

        // ADDS R1,R2,R3
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110);
        run(0, 0);
        chk("adds_seq", seq, 32'h0168);
        chk("adds_cyc", 32'(cyc_n), 32'd4);
        chk("adds_rw", 32'(rw_n), 32'd1);
        chk("adds_ctl", 32'(ctl_ex), 32'd0);
        chk("adds_flags", 32'(bus.flags_q), 32'h6);
        chk("adds_pwlate", 32'(pw_late_n), 32'd0);

        // SUBEQ R0 with Z=1 executes
        set_instr(4'b0000, 2'b00, 6'b000100, 4'd0, 4'b1111);
        run(0, 0);
        chk("subeq_z1_rw", 32'(rw_n), 32'd1);
        chk("subeq_ctl", 32'(ctl_ex), 32'd1);
        chk("subeq_flags", 32'(bus.flags_q), 32'h6);

        // ANDS updates only N,Z
        set_instr(4'b1110, 2'b00, 6'b000001, 4'd3, 4'b1001);
        run(0, 0);
        chk("ands_ctl", 32'(ctl_ex), 32'd2);
        chk("ands_flags", 32'(bus.flags_q), 32'hA);

        // SUBEQS with Z=0 is suppressed entirely
        set_instr(4'b0000, 2'b00, 6'b000101, 4'd0, 4'b0100);
        run(0, 0);
        chk("subeq_z0_rw", 32'(rw_n), 32'd0);
        chk("subeq_z0_flags", 32'(bus.flags_q), 32'hA);

        // ORR immediate, no S
        set_instr(4'b1110, 2'b00, 6'b111000, 4'd3, 4'b1111);
        run(0, 0);
        chk("orr_seq", seq, 32'h0178);
        chk("orr_ctl", 32'(ctl_ex), 32'd3);
        chk("orr_flags", 32'(bus.flags_q), 32'hA);

        // cond=1111 never executes
        set_instr(4'b1111, 2'b00, 6'b001000, 4'd3, 4'b0000);
        run(0, 0);
        chk("nv_rw", 32'(rw_n), 32'd0);

        // LDR with two MEMRD stalls
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
        run(0, 2);
        chk("ldr_seq", seq, 32'h0123334);
        chk("ldr_cyc", 32'(cyc_n), 32'd7);
        chk("ldr_rw", 32'(rw_n), 32'd1);
        chk("ldr_src", 32'(src_at_rw), 32'd1);
        chk("ldr_mw", 32'(mw_n), 32'd0);

        // STR with one MEMWR stall
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000);
        run(0, 1);
        chk("str_seq", seq, 32'h01255);
        chk("str_mw", 32'(mw_n), 32'd2);
        chk("str_rw", 32'(rw_n), 32'd0);

        // B
        set_instr(4'b1110, 2'b10, 6'b100000, 4'd0, 4'b0000);
        run(0, 0);
        chk("b_seq", seq, 32'h019);
        chk("b_cyc", 32'(cyc_n), 32'd3);
        chk("b_pwlate", 32'(pw_late_n), 32'd1);
        chk("b_src", 32'(src_at_pw), 32'd2);

        // B with one FETCH stall
        run(1, 0);
        chk("bw_cyc", 32'(cyc_n), 32'd4);
        chk("bw_ir", 32'(ir_n), 32'd1);
        chk("bw_pw", 32'(pw_n), 32'd2);

        // ADD R15 writes the PC in ALUWB
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
        run(0, 0);
        chk("addpc_seq", seq, 32'h0168);
        chk("addpc_pwlate", 32'(pw_late_n), 32'd1);
        chk("addpc_rw", 32'(rw_n), 32'd1);

        // Undefined op
        set_instr(4'b1110, 2'b11, 6'b001000, 4'd1, 4'b0000);
        run(0, 0);
        chk("undef_seq", seq, 32'h01);
        chk("undef_writes", 32'(rw_n + mw_n + pw_late_n), 32'd0);

        // Reset asserted mid-LDR
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b1111);
        bus.mem_ready = 1'b1;
        step();
        step();
        chk("mid_pre_state", 32'(bus.state), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_flags", 32'(bus.flags_q), 32'h0);
        chk("mid_rst_wr", 32'({bus.reg_write, bus.mem_write}), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("mid_restart", 32'(bus.state), 32'd1);
        step();
        step();
        step();
        step();
        chk("mid_ldr_done", 32'(bus.state), 32'd0);

        // MEM_WAIT=0 ignores mem_ready
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000);
        bus.mem_ready = 1'b0;
        rst0 = 1'b1;
        #1;
        chk("nw_fetch_pcw", 32'(bus0.pc_write), 32'd1);
        chk("mw_fetch_stall_irw", 32'(bus.ir_write), 32'd0);
        step();
        chk("nw_decode", 32'(bus0.state), 32'd1);
        chk("mw_stalled", 32'(bus.state), 32'd0);
        step();
        step();
        chk("nw_memwr", 32'(bus0.state), 32'd5);
        chk("nw_mw", 32'(bus0.mem_write), 32'd1);
        step();
        chk("nw_back", 32'(bus0.state), 32'd0);
        chk("nw_mw_off", 32'(bus0.mem_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
